// File: rtl/fir_check_pkg.sv
// Shared types and constants for the FIR result checker.
package fir_check_pkg;

    // Run-control states of the checker.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Default sample width (two's complement) of the filter datapath.
    localparam int DATA_W_DEF = 17;

    // Default counter width and the "no failure seen" index marker.
    localparam int                    CNT_W_DEF  = 16;
    localparam logic [CNT_W_DEF-1:0]  NO_ERR_IDX = '1;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register carrying {valid, data}; advances every cycle.
// any_valid_o tells the owner whether any entry is still in flight.
module valid_delay_line #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_v_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_v_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             any_valid_o
);

    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;

    // Shift every cycle; stage 0 takes the new entry, valid bits cleared on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            d_q <= '0;
        end else begin
            v_q[0] <= in_v_i;
            d_q[0] <= in_data_i;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign out_v_o     = v_q[DEPTH-1];
    assign out_data_o  = d_q[DEPTH-1];
    assign any_valid_o = |v_q;

endmodule

// File: rtl/fir_result_checker.sv
// Receive/compare end of the FIR sample stream: delays each expected value
// by the filter latency, compares it with the filter output and gathers
// error statistics over a run of num_samples samples.
module fir_result_checker
    import fir_check_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = 8,           // must be >= 1
    parameter int TOL     = 4,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              valid,
    input  logic [DATA_W-1:0] exp_y,
    input  logic [DATA_W-1:0] y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              mismatch,
    output logic [CNT_W-1:0]  err_count,
    output logic [DATA_W:0]   max_abs_err,
    output logic [CNT_W-1:0]  first_err_idx
);

    localparam logic [DATA_W:0] TOL_V = (DATA_W+1)'(TOL);

    state_e             state_q, state_d;
    logic               start_ok;
    logic               push;
    logic               last_in;
    logic [CNT_W-1:0]   num_q, in_cnt_q;
    logic [CNT_W-1:0]   out_idx_q;
    logic [CNT_W-1:0]   err_count_q, first_err_idx_q;
    logic [DATA_W:0]    max_abs_err_q;
    logic               mismatch_q, pass_q, done_q, done_arm_q;

    logic               cmp_v, any_valid;
    logic [DATA_W-1:0]  cmp_exp;
    logic signed [DATA_W:0] y_s, exp_s, diff;
    logic [DATA_W:0]    abs_err;
    logic               fail;

    assign push    = (state_q == RUN) && valid;
    assign last_in = (in_cnt_q + CNT_W'(1)) == num_q;

    valid_delay_line #(
        .WIDTH (DATA_W),
        .DEPTH (LATENCY)
    ) u_dly (
        .clk_i       (clk_100MHz),
        .rst_ni      (reset),
        .in_v_i      (push),
        .in_data_i   (exp_y),
        .out_v_o     (cmp_v),
        .out_data_o  (cmp_exp),
        .any_valid_o (any_valid)
    );

    // Stage C: widen by one bit so the difference of two extremes cannot wrap.
    assign y_s     = {y[DATA_W-1], y};
    assign exp_s   = {cmp_exp[DATA_W-1], cmp_exp};
    assign diff    = y_s - exp_s;
    assign abs_err = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
    assign fail    = cmp_v && (abs_err > TOL_V);

    // Next-state logic; a start is only honoured from IDLE or DONE.
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN:     if (push && last_in) state_d = DRAIN;
            DRAIN:   if (!any_valid)      state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Run length latch and input-side sample counter.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            num_q    <= '0;
            in_cnt_q <= '0;
        end else if (start_ok) begin
            num_q    <= num_samples;
            in_cnt_q <= '0;
        end else if (push) begin
            in_cnt_q <= in_cnt_q + CNT_W'(1);
        end
    end

    // Result register: statistics cleared on accepted start, updated per compare.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            out_idx_q       <= '0;
            err_count_q     <= '0;
            max_abs_err_q   <= '0;
            first_err_idx_q <= '1;
            mismatch_q      <= 1'b0;
        end else begin
            mismatch_q <= fail;
            if (start_ok) begin
                out_idx_q       <= '0;
                err_count_q     <= '0;
                max_abs_err_q   <= '0;
                first_err_idx_q <= '1;
            end else if (cmp_v) begin
                out_idx_q <= out_idx_q + CNT_W'(1);
                if (abs_err > max_abs_err_q) max_abs_err_q <= abs_err;
                if (fail) begin
                    if (err_count_q != '1) err_count_q     <= err_count_q + CNT_W'(1);
                    if (err_count_q == '0) first_err_idx_q <= out_idx_q;
                end
            end
        end
    end

    // Verdict on entry to DONE; done pulses in the cycle after entry.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            pass_q     <= 1'b0;
            done_arm_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_arm_q <= (state_d == DONE) && ((state_q != DONE) || start_ok);
            done_q     <= done_arm_q && !start_ok;
            if (start_ok)
                pass_q <= (num_samples == '0);
            else if ((state_q == DRAIN) && (state_d == DONE))
                pass_q <= (err_count_q == '0);
        end
    end

    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = done_q;
    assign pass          = pass_q;
    assign mismatch      = mismatch_q;
    assign err_count     = err_count_q;
    assign max_abs_err   = max_abs_err_q;
    assign first_err_idx = first_err_idx_q;

endmodule

// File: doc/fir_result_checker.md
Name: fir_result_checker

Overview:
- Synthesizable self-check block for the low-pass FIR datapath; it is the receive/compare end of the sample stream.
- Takes each expected output value at the filter's input strobe and delays it by the filter latency.
- Compares the delayed value against the filter output `y` and accumulates error statistics for a run of N samples.
- Sits beside `top` on the FPGA: the stimulus source drives `x`, `valid` and `exp_y`; results go to LEDs/debug.

Parameters:
- DATA_W, 17, sample width, two's complement
- LATENCY, 8, cycles from `valid` sample entering the filter to matching `y`; must be >= 1
- TOL, 4, maximum allowed absolute error in LSBs (inclusive)
- CNT_W, 16, width of sample/error counters

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a run; ignored unless IDLE or DONE
- num_samples  in  CNT_W  samples in run; latched on accepted start
- valid  in  1  sample strobe, same cycle as `x` into the filter
- exp_y  in  DATA_W  expected filter output for this sample
- y  in  DATA_W  filter output (aligned LATENCY cycles after valid)
- busy  out  1  high in RUN/DRAIN
- done  out  1  one-cycle pulse when run finishes
- pass  out  1  1 if err_count==0; valid from done until next accepted start
- mismatch  out  1  one-cycle pulse per failing compare
- err_count  out  CNT_W  failing compares, saturating
- max_abs_err  out  DATA_W+1  largest |y-exp| seen in run
- first_err_idx  out  CNT_W  sample index (0-based) of first failure; all-ones if none

Behaviour:
- Reset values (async, active-low):
  - state=IDLE; busy=0, done=0, mismatch=0.
  - pass=0, err_count=0, max_abs_err=0, first_err_idx=all-ones.
  - Delay line cleared (all valid bits 0).
- FSM states:
  - IDLE: waits for start. On start, latch num_samples and clear stats/counters.
    - num_samples==0 -> DONE next cycle.
    - Otherwise -> RUN.
  - RUN: each cycle with valid=1 pushes {1,exp_y} into the delay line and increments in_cnt. valid is not pushed outside RUN. When in_cnt reaches num_samples (on the push of the last sample) -> DRAIN.
  - DRAIN: no pushes. When no valid bit remains in the delay line and the final compare has been registered -> DONE.
  - DONE: done=1 for exactly one cycle, then stay in DONE. Stats hold. start -> same as IDLE handling.
- Delay line: LATENCY-deep shift register of {v, exp}, advanced every cycle (not gated by valid).
- Compare (stage C):
  - Fires when the delay-line output v=1.
  - Sign-extend y and exp to DATA_W+1, subtract, take absolute value as an unsigned DATA_W+1 result. |(-2^16) - (2^16-1)| = 2^17-1 must not overflow.
  - Fail if abs_err > TOL.
- Result register, one cycle after stage C:
  - mismatch pulses on fail.
  - err_count increments on fail and saturates at all-ones.
  - max_abs_err = max(current, abs_err).
  - first_err_idx is loaded with out_idx on the first fail only.
  - out_idx increments per compare.
- Latency: mismatch rises LATENCY+1 cycles after the valid that carried the failing exp_y.
- pass is registered on entry to DONE: pass = (err_count==0), including the final compare.
- start while busy is ignored (no restart, stats untouched).
- Reset mid-run discards the run entirely; the block returns to the IDLE reset values.
- `y` is sampled only on compare cycles; X on `y` at other times is harmless.

Decomposition:
- Package `fir_check_pkg`:
  - state enum: IDLE, RUN, DRAIN, DONE
  - DATA_W default constant
  - all-ones NO_ERR_IDX constant
- Sub-module `valid_delay_line` (params WIDTH, DEPTH): shift register with per-stage valid and an any_valid output used by DRAIN exit.
- All remaining logic (FSM, compare, stats) stays in `fir_result_checker`.

Test Plan:
- Match run:
  - Stimulus: num_samples=10, LATENCY=8; drive y = exp_y delayed exactly 8 cycles.
  - Required: done once, pass=1, err_count=0, max_abs_err=0, first_err_idx=16'hFFFF, mismatch never high.
- Single error:
  - Stimulus: sample 3 has exp_y=17'h00100, y=17'h00110.
  - Required: mismatch pulse 9 cycles after sample-3 valid; err_count=1, first_err_idx=3, max_abs_err=16, pass=0.
- Tolerance boundary:
  - Stimulus: abs errors of 4 and 5 on samples 0 and 1, TOL=4.
  - Required: only sample 1 fails; err_count=1, first_err_idx=1, max_abs_err=5.
- Extreme values:
  - Stimulus: exp_y=17'h0FFFF, y=17'h10000.
  - Required: max_abs_err=18'h1FFFF, fail flagged.
- Zero-length run:
  - Stimulus: start with num_samples=0.
  - Required: busy never high, done pulses 2 cycles after start, pass=1.
- Reset and restart:
  - Stimulus: assert reset low in RUN after 5 samples, release, then issue a new start with 4 clean samples.
  - Required: all outputs return to reset values; new run gives pass=1, err_count=0; start pulses during RUN are ignored.
